// File: rtl/ha_resp_checker.sv
`default_nettype none
// ============================================================================
// Module      : ha_resp_checker
// Description : Checks observed half-adder responses against a^b / a&b and
//               reports vector/fail counts plus the first failing vector.
// Revision    : 1.0 - initial release
// ============================================================================
module ha_resp_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             vld,
    input  logic             a,
    input  logic             b,
    input  logic             cout,
    input  logic             sum,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [3:0]       first_fail_obs
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_zero = '0;
    localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;

    state_t           r_state;
    logic [CNT_W-1:0] r_num_vec;

    logic             w_mismatch;
    logic [CNT_W-1:0] w_vec_next;

    assign w_mismatch = (sum != (a ^ b)) || (cout != (a & b));
    assign w_vec_next = vec_cnt + c_cnt_one;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_num_vec      <= c_cnt_zero;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err            <= 1'b0;
            vec_cnt        <= c_cnt_zero;
            fail_cnt       <= c_cnt_zero;
            first_fail_idx <= c_cnt_zero;
            first_fail_obs <= 4'd0;
        end else begin
            err <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_num_vec      <= num_vec;
                        vec_cnt        <= c_cnt_zero;
                        fail_cnt       <= c_cnt_zero;
                        first_fail_idx <= c_cnt_zero;
                        first_fail_obs <= 4'd0;
                        // An empty run has nothing to check and trivially passes.
                        if (num_vec == c_cnt_zero) begin
                            r_state <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                            pass    <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (vld) begin
                        vec_cnt <= w_vec_next;
                        if (w_mismatch) begin
                            err <= 1'b1;
                            if (fail_cnt != c_cnt_max) begin
                                fail_cnt <= fail_cnt + c_cnt_one;
                            end
                            if (fail_cnt == c_cnt_zero) begin
                                first_fail_idx <= vec_cnt;
                                first_fail_obs <= {a, b, cout, sum};
                            end
                        end
                        // Pass must fold in the vector checked on this same edge.
                        if (w_vec_next == r_num_vec) begin
                            r_state <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (fail_cnt == c_cnt_zero) && !w_mismatch;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    pass    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ha_resp_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ha_resp_checker
// Description : Directed table-driven bench for ha_resp_checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ha_resp_checker;

    logic       clk = 1'b0;
    logic       rst, start, vld, a, b, cout, sum;
    logic [7:0] num_vec;
    logic       busy, done, pass, err;
    logic [7:0] vec_cnt, fail_cnt, first_fail_idx;
    logic [3:0] first_fail_obs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ha_resp_checker #(.CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_vec        (num_vec),
        .vld            (vld),
        .a              (a),
        .b              (b),
        .cout           (cout),
        .sum            (sum),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err            (err),
        .vec_cnt        (vec_cnt),
        .fail_cnt       (fail_cnt),
        .first_fail_idx (first_fail_idx),
        .first_fail_obs (first_fail_obs)
    );

    typedef struct packed {
        logic        rst;
        logic        start;
        logic [7:0]  nv;
        logic        vld;
        logic [3:0]  abcs;
        logic [31:0] exp;
    } vec_t;

    // Packed view of every output: {busy,done,pass,err,vec,fail,idx,obs}
    function automatic logic [31:0] ex(input logic bz, input logic dn, input logic ps,
                                       input logic er, input logic [7:0] vc,
                                       input logic [7:0] fc, input logic [7:0] fi,
                                       input logic [3:0] fo);
        return {bz, dn, ps, er, vc, fc, fi, fo};
    endfunction

    function automatic vec_t mk(input logic r, input logic s, input logic [7:0] nv,
                                input logic v, input logic [3:0] abcs,
                                input logic [31:0] e);
        vec_t t;
        t.rst = r; t.start = s; t.nv = nv; t.vld = v; t.abcs = abcs; t.exp = e;
        return t;
    endfunction

    function automatic logic [31:0] outs();
        return {busy, done, pass, err, vec_cnt, fail_cnt, first_fail_idx, first_fail_obs};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic [7:0] nv,
                         input logic v, input logic [3:0] abcs);
        @(negedge clk);
        rst = r; start = s; num_vec = nv; vld = v;
        {a, b, cout, sum} = abcs;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[25];
    int   err_seen;

    initial begin
        rst = 1'b1; start = 1'b0; num_vec = 8'd0; vld = 1'b0;
        a = 1'b0; b = 1'b0; cout = 1'b0; sum = 1'b0;

        //                rst start nv  vld {a,b,co,s}  busy done pass err vc fc fi fo
        tbl[0]  = mk(1, 0, 0, 0, 4'b0000, ex(0,0,0,0, 0,0,0,4'h0));
        tbl[1]  = mk(0, 1, 4, 0, 4'b0000, ex(1,0,0,0, 0,0,0,4'h0));
        tbl[2]  = mk(0, 0, 0, 1, 4'b0000, ex(1,0,0,0, 1,0,0,4'h0));
        tbl[3]  = mk(0, 0, 0, 1, 4'b0101, ex(1,0,0,0, 2,0,0,4'h0));
        tbl[4]  = mk(0, 0, 0, 1, 4'b1001, ex(1,0,0,0, 3,0,0,4'h0));
        tbl[5]  = mk(0, 0, 0, 1, 4'b1110, ex(0,1,1,0, 4,0,0,4'h0));
        tbl[6]  = mk(0, 0, 0, 1, 4'b1100, ex(0,1,1,0, 4,0,0,4'h0));
        tbl[7]  = mk(0, 1, 4, 0, 4'b0000, ex(1,0,0,0, 0,0,0,4'h0));
        tbl[8]  = mk(0, 0, 0, 1, 4'b0000, ex(1,0,0,0, 1,0,0,4'h0));
        tbl[9]  = mk(0, 0, 0, 1, 4'b1000, ex(1,0,0,1, 2,1,1,4'h8));
        tbl[10] = mk(0, 0, 0, 1, 4'b1001, ex(1,0,0,0, 3,1,1,4'h8));
        tbl[11] = mk(0, 0, 0, 1, 4'b1110, ex(0,1,0,0, 4,1,1,4'h8));
        tbl[12] = mk(0, 1, 0, 0, 4'b0000, ex(0,1,1,0, 0,0,0,4'h0));
        tbl[13] = mk(0, 1, 2, 1, 4'b1100, ex(1,0,0,0, 0,0,0,4'h0));
        tbl[14] = mk(0, 1, 7, 1, 4'b1110, ex(1,0,0,0, 1,0,0,4'h0));
        tbl[15] = mk(0, 0, 0, 1, 4'b1100, ex(0,1,0,1, 2,1,1,4'hC));
        tbl[16] = mk(0, 0, 0, 0, 4'b0000, ex(0,1,0,0, 2,1,1,4'hC));
        tbl[17] = mk(0, 1, 4, 0, 4'b0000, ex(1,0,0,0, 0,0,0,4'h0));
        tbl[18] = mk(0, 0, 0, 1, 4'b0100, ex(1,0,0,1, 1,1,0,4'h4));
        tbl[19] = mk(0, 0, 0, 1, 4'b0000, ex(1,0,0,0, 2,1,0,4'h4));
        tbl[20] = mk(1, 1, 4, 1, 4'b1100, ex(0,0,0,0, 0,0,0,4'h0));
        tbl[21] = mk(0, 0, 0, 1, 4'b1100, ex(0,0,0,0, 0,0,0,4'h0));
        tbl[22] = mk(0, 1, 1, 0, 4'b0000, ex(1,0,0,0, 0,0,0,4'h0));
        tbl[23] = mk(0, 0, 0, 0, 4'b1100, ex(1,0,0,0, 0,0,0,4'h0));
        tbl[24] = mk(0, 0, 0, 1, 4'b1001, ex(0,1,1,0, 1,0,0,4'h0));

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].rst, tbl[i].start, tbl[i].nv, tbl[i].vld, tbl[i].abcs);
            check($sformatf("row%0d", i), outs(), tbl[i].exp);
        end

        // Gaps of 0..5 idle cycles between vectors of a 3-vector run
        drive(0, 1, 3, 0, 4'b0000);
        drive(0, 0, 0, 1, 4'b0101);
        for (int g = 0; g < 5; g++) drive(0, 0, 0, 0, 4'b1100);
        check("gap_mid", outs(), ex(1,0,0,0, 1,0,0,4'h0));
        drive(0, 0, 0, 1, 4'b0000);
        for (int g = 0; g < 3; g++) drive(0, 0, 0, 0, 4'b0000);
        drive(0, 0, 0, 1, 4'b1110);
        check("gap_done", outs(), ex(0,1,1,0, 3,0,0,4'h0));

        // 255 wrong vectors: fail counter reaches its ceiling
        err_seen = 0;
        drive(0, 1, 255, 0, 4'b0000);
        for (int k = 0; k < 255; k++) begin
            drive(0, 0, 0, 1, 4'b0011);
            if (err) err_seen++;
        end
        check("sat_end", outs(), ex(0,1,0,1, 255,255,0,4'h3));
        check("sat_errs", 32'(err_seen), 32'd255);
        drive(0, 0, 0, 0, 4'b0000);
        check("sat_hold", outs(), ex(0,1,0,0, 255,255,0,4'h3));

        // Restart with start held high from a failing DONE
        drive(0, 1, 3, 0, 4'b0000);
        check("rs_clear", outs(), ex(1,0,0,0, 0,0,0,4'h0));
        drive(0, 1, 9, 1, 4'b0101);
        drive(0, 1, 9, 1, 4'b1001);
        check("rs_ignore", outs(), ex(1,0,0,0, 2,0,0,4'h0));
        drive(0, 0, 0, 1, 4'b1110);
        check("rs_pass", outs(), ex(0,1,1,0, 3,0,0,4'h0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
